rf_access_arbiter: RTL and testbench
====================================

Name: rf_access_arbiter

Overview:
- Shares the 16x16-bit, two-read/one-write register file between two requesters: 0 = processor datapath, 1 = host/debug port.
- Round-robin arbitration with a req/gnt/vld handshake.
- All register-file control signals come from registered state, so the register file is never driven directly by requester inputs.
- Sits between the requesters and the register file. It is the only driver of the register-file write, read-address and read-enable inputs.

Parameters:
- DATA_W, 16, data width of register file words
- ADDR_W, 4, register address width (16 registers)

Ports:
- Clk  in  1  system clock
- Reset  in  1  one clock; reset is synchronous and active-low
- Req[x] (x=0,1)  in  1  transaction request; held with fields stable until Gnt[x] seen
- We[x]  in  1  1=write, 0=read (two-operand read)
- RAddrA[x], RAddrB[x]  in  ADDR_W  read addresses for ports 0 and 1
- WAddr[x]  in  ADDR_W  write address
- WData[x]  in  DATA_W  write data
- Gnt[x]  out  1  one-cycle pulse: transaction accepted and executing
- Vld[x]  out  1  one-cycle pulse: transaction complete; read data valid
- RDataA[x], RDataB[x]  out  DATA_W  captured read data; held until next read completes for x
- RF_W_data  out  DATA_W;  RF_W_addr  out  ADDR_W;  RF_W_en  out  1
- RF_R_addr0, RF_R_addr1  out  ADDR_W;  RF_R_en0, RF_R_en1  out  1
- RF_R_data0, RF_R_data1  in  DATA_W  register file read buses (tri-state, Z when not enabled)
- Busy  out  1  high in EXEC and RESP

Behaviour:
- Reset (Reset=0 at a Clk edge):
  - state=IDLE; priority pointer=0.
  - Gnt, Vld, RData*, all RF_* outputs, and the transaction register clear to 0.
  - Reset overrides any in-flight transaction: no RF_W_en after that edge, and no Vld for the aborted transaction.
- States:
  - IDLE: no requests pending.
  - EXEC: drive the register file.
  - RESP: report completion.
- Accept: occurs at an edge leaving IDLE or RESP when Req0|Req1.
  - Winner = the sole requester, or, if both, the one named by the pointer.
  - Capture We/addresses/WData plus the winner index into the transaction register; go to EXEC.
  - Pointer := other requester, after every accept.
- EXEC (exactly 1 cycle):
  - Gnt[winner]=1.
  - Write: RF_W_en=1, RF_W_addr/RF_W_data from the transaction register. The register file updates at the edge ending EXEC.
  - Read: RF_R_en0=RF_R_en1=1, RF_R_addr0/1 = captured RAddrA/RAddrB. RF_R_data0/1 are captured into RDataA/RDataB[winner] at the edge ending EXEC.
  - The other requester's RData is unchanged.
  - Next state is always RESP.
- RESP (1 cycle):
  - Vld[winner]=1. RData valid for reads; writes pulse Vld only.
  - If any Req is high, accept per the rules above and go to EXEC. Otherwise go to IDLE.
- Outside EXEC:
  - RF_W_en=RF_R_en0=RF_R_en1=0.
  - RF addresses/data hold the last transaction values; they are don't-care.
- Handshake:
  - The requester drops Req in the cycle after the Gnt edge unless it presents a new transaction with new fields.
  - A requester still asserting Req in RESP is treated as a new transaction.
- Latency and throughput:
  - Req high in IDLE -> Gnt next cycle -> Vld the cycle after.
  - Back-to-back throughput is one transaction per 2 cycles.
- Fairness: if both hold Req continuously, grants alternate 0,1,0,1 starting from the pointer.
- Ordering: a write followed by a read of the same address observes the new value, because the stages are sequential. No bypass is needed.
- Register 0 receives no special treatment; it is readable and writable like any other register.

Decomposition:
- Package rf_arb_pkg:
  - state enum {IDLE, EXEC, RESP}
  - DATA_W/ADDR_W defaults
  - transaction struct {we, raddr_a, raddr_b, waddr, wdata, owner}
- Sub-module rr_arbiter2: combinational 2-way pick from Req and pointer. It outputs the winner index and a valid flag. The pointer register stays in the parent.

Test Plan:
- Reset mid-write: Req0 write R5=16'hBEEF, assert Reset=0 during EXEC -> RF_W_en=0 after the edge, R5 unchanged, no Vld0, all outputs 0.
- Single write then read: Req0 write R3=16'h1234; then Req0 read A=R3, B=R0 (R0=0) -> Gnt0 at +1, Vld0 at +2, RDataA0=16'h1234, RDataB0=16'h0000.
- Simultaneous requests after reset: Req0 and Req1 both read -> Gnt0 first, then Gnt1 two cycles later (pointer=0 at reset); pointer ends at 0.
- Continuous contention over 6 transactions: both hold Req -> grant sequence 0,1,0,1,0,1, one grant every 2 cycles, Busy never low.
- Cross-requester hazard: Req1 write R15=16'hFFFF, then Req0 read A=R15 -> RDataA0=16'hFFFF; RDataA1 unchanged.
- Tri-state check: in IDLE -> RF_R_en0=RF_R_en1=RF_W_en=0 and RData regs hold prior values while RF_R_data buses are Z.

Source files
------------

// File: rtl/rf_access_arbiter_pkg.sv
// Shared types for the register-file access arbiter: FSM states and the
// captured transaction record.
package rf_arb_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] raddr_a;
        logic [ADDR_W-1:0] raddr_b;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic              owner;
    } txn_t;

endpackage

// File: rtl/rf_access_arbiter_if.sv
// Requester handshake plus register-file bus seen by the arbiter.
// Index 0 is the processor datapath and index 1 is the host/debug port.
interface rf_access_arbiter_if #(
    parameter int unsigned DATA_W = rf_arb_pkg::DATA_W,
    parameter int unsigned ADDR_W = rf_arb_pkg::ADDR_W
);
    logic [1:0]        Req;
    logic [1:0]        We;
    logic [ADDR_W-1:0] RAddrA [2];
    logic [ADDR_W-1:0] RAddrB [2];
    logic [ADDR_W-1:0] WAddr  [2];
    logic [DATA_W-1:0] WData  [2];
    logic [1:0]        Gnt;
    logic [1:0]        Vld;
    logic [DATA_W-1:0] RDataA [2];
    logic [DATA_W-1:0] RDataB [2];
    logic              Busy;

    logic [DATA_W-1:0] RF_W_data;
    logic [ADDR_W-1:0] RF_W_addr;
    logic              RF_W_en;
    logic [ADDR_W-1:0] RF_R_addr0;
    logic [ADDR_W-1:0] RF_R_addr1;
    logic              RF_R_en0;
    logic              RF_R_en1;
    logic [DATA_W-1:0] RF_R_data0;
    logic [DATA_W-1:0] RF_R_data1;

    modport slave (
        input  Req, We, RAddrA, RAddrB, WAddr, WData, RF_R_data0, RF_R_data1,
        output Gnt, Vld, RDataA, RDataB, Busy,
               RF_W_data, RF_W_addr, RF_W_en,
               RF_R_addr0, RF_R_addr1, RF_R_en0, RF_R_en1
    );

    modport master (
        output Req, We, RAddrA, RAddrB, WAddr, WData, RF_R_data0, RF_R_data1,
        input  Gnt, Vld, RDataA, RDataB, Busy,
               RF_W_data, RF_W_addr, RF_W_en,
               RF_R_addr0, RF_R_addr1, RF_R_en0, RF_R_en1
    );

endinterface

// File: rtl/rf_access_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick; the pointer register lives in the
// parent.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = (req == 2'b11) ? ptr : req[1];
    end

endmodule

// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter giving two requesters sequential access to a
// 2-read/1-write register file: accept -> EXEC (drive RF) -> RESP (report).
module rf_access_arbiter #(
    parameter int unsigned DATA_W = rf_arb_pkg::DATA_W,
    parameter int unsigned ADDR_W = rf_arb_pkg::ADDR_W
) (
    input logic           Clk,
    input logic           Reset,
    rf_access_arbiter_if.slave bus
);
    import rf_arb_pkg::*;

    state_t state;
    txn_t   txn;
    txn_t   nxt;
    logic   ptr;
    logic   win;
    logic   win_vld;

    rr_arbiter2 u_pick (
        .req    (bus.Req),
        .ptr    (ptr),
        .winner (win),
        .valid  (win_vld)
    );

    always_comb begin
        nxt         = '0;
        nxt.we      = bus.We[win];
        nxt.raddr_a = bus.RAddrA[win];
        nxt.raddr_b = bus.RAddrB[win];
        nxt.waddr   = bus.WAddr[win];
        nxt.wdata   = bus.WData[win];
        nxt.owner   = win;
    end

    // RF controls decode only the state and transaction registers, so
    // requester inputs never reach the register file directly.
    assign bus.RF_W_en    = (state == EXEC) &&  txn.we;
    assign bus.RF_R_en0   = (state == EXEC) && !txn.we;
    assign bus.RF_R_en1   = (state == EXEC) && !txn.we;
    assign bus.RF_W_addr  = txn.waddr[ADDR_W-1:0];
    assign bus.RF_W_data  = txn.wdata[DATA_W-1:0];
    assign bus.RF_R_addr0 = txn.raddr_a[ADDR_W-1:0];
    assign bus.RF_R_addr1 = txn.raddr_b[ADDR_W-1:0];
    assign bus.Busy       = (state != IDLE);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            txn     <= '0;
            bus.Gnt <= '0;
            bus.Vld <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                bus.RDataA[i] <= '0;
                bus.RDataB[i] <= '0;
            end
        end else begin
            bus.Gnt <= '0;
            bus.Vld <= '0;
            unique case (state)
                IDLE, RESP: begin
                    if (win_vld) begin
                        txn          <= nxt;
                        ptr          <= ~win;
                        bus.Gnt[win] <= 1'b1;
                        state        <= EXEC;
                    end else begin
                        state <= IDLE;
                    end
                end
                EXEC: begin
                    if (!txn.we) begin
                        bus.RDataA[txn.owner] <= bus.RF_R_data0;
                        bus.RDataB[txn.owner] <= bus.RF_R_data1;
                    end
                    bus.Vld[txn.owner] <= 1'b1;
                    state              <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed and random checks of rf_access_arbiter against a timeline-based
// reference model and a behavioural register file.
module tb_rf_access_arbiter;

    localparam int DW = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rf_access_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    rf_access_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    // Register file shares the system reset and ignores writes while held in it.
    logic [DW-1:0] rf_mem [16] = '{default: '0};
    always @(posedge clk) if (rst_n && bus.RF_W_en) rf_mem[bus.RF_W_addr] <= bus.RF_W_data;
    assign bus.RF_R_data0 = bus.RF_R_en0 ? rf_mem[bus.RF_R_addr0] : 'z;
    assign bus.RF_R_data1 = bus.RF_R_en1 ? rf_mem[bus.RF_R_addr1] : 'z;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: transactions on a timeline of clock edges.
    int            cur = 0;
    int            free_edge = 0;
    int            t_edge = 0;
    bit            have = 0;
    bit            m_ptr = 0;
    bit            t_owner, t_we;
    logic [AW-1:0] t_ra, t_rb, t_wa;
    logic [DW-1:0] t_wd;
    logic [DW-1:0] exp_mem [16] = '{default: '0};
    logic [DW-1:0] exp_ra [2] = '{default: '0};
    logic [DW-1:0] exp_rb [2] = '{default: '0};
    logic [1:0]    exp_vld = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int e;
        bit w;
        e = cur + 1;
        exp_vld = '0;
        if (!rst_n) begin
            have = 0; m_ptr = 0; free_edge = 0;
            for (int i = 0; i < 2; i++) begin exp_ra[i] = '0; exp_rb[i] = '0; end
            return;
        end
        if (have && e == t_edge + 1) begin
            if (t_we) exp_mem[t_wa] = t_wd;
            else begin
                exp_ra[t_owner] = exp_mem[t_ra];
                exp_rb[t_owner] = exp_mem[t_rb];
            end
            exp_vld[t_owner] = 1'b1;
        end
        if (e >= free_edge && bus.Req != 2'b00) begin
            w = (bus.Req == 2'b11) ? m_ptr : bus.Req[1];
            t_owner = w; t_we = bus.We[w];
            t_ra = bus.RAddrA[w]; t_rb = bus.RAddrB[w];
            t_wa = bus.WAddr[w];  t_wd = bus.WData[w];
            t_edge = e; free_edge = e + 2; m_ptr = !w; have = 1;
        end
    endtask

    task automatic check_all();
        bit         act;
        logic [1:0] eg;
        act = have && (t_edge == cur);
        eg  = act ? (t_owner ? 2'b10 : 2'b01) : 2'b00;
        check("gnt", bus.Gnt, eg);
        check("vld", bus.Vld, exp_vld);
        check("busy", bus.Busy, cur < free_edge);
        check("w_en", bus.RF_W_en, act && t_we);
        check("r_en0", bus.RF_R_en0, act && !t_we);
        check("r_en1", bus.RF_R_en1, act && !t_we);
        if (act && t_we) begin
            check("w_addr", bus.RF_W_addr, t_wa);
            check("w_data", bus.RF_W_data, t_wd);
        end
        if (act && !t_we) begin
            check("r_addr0", bus.RF_R_addr0, t_ra);
            check("r_addr1", bus.RF_R_addr1, t_rb);
        end
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rdata_a%0d", i), bus.RDataA[i], exp_ra[i]);
            check($sformatf("rdata_b%0d", i), bus.RDataB[i], exp_rb[i]);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        cur++;
        @(negedge clk);
        check_all();
    endtask

    task automatic set_txn(input int x, input bit we, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                           input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        bus.We[x] = we; bus.RAddrA[x] = ra; bus.RAddrB[x] = rb;
        bus.WAddr[x] = wa; bus.WData[x] = wd;
    endtask

    task automatic rand_txn(input int x);
        set_txn(x, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 16'($urandom));
    endtask

    initial begin
        int last;
        int grants;
        int w;

        rst_n = 1'b0;
        bus.Req = '0;
        set_txn(0, 0, '0, '0, '0, '0);
        set_txn(1, 0, '0, '0, '0, '0);
        tick(); tick();
        check("rst_w_addr", bus.RF_W_addr, 0);
        check("rst_w_data", bus.RF_W_data, 0);
        check("rst_r_addr0", bus.RF_R_addr0, 0);
        check("rst_r_addr1", bus.RF_R_addr1, 0);
        rst_n = 1'b1;
        tick();

        // Reset while a write is executing
        set_txn(0, 1, '0, '0, 4'd5, 16'hBEEF);
        bus.Req[0] = 1'b1;
        tick();
        check("midw_gnt", bus.Gnt, 2'b01);
        check("midw_wen", bus.RF_W_en, 1);
        bus.Req[0] = 1'b0;
        rst_n = 1'b0;
        tick();
        check("midw_wen_after", bus.RF_W_en, 0);
        rst_n = 1'b1;
        tick();
        check("midw_novld", bus.Vld, 2'b00);
        tick();
        check("midw_r5", rf_mem[5], 16'h0000);

        // Write R3 then read R3/R0
        set_txn(0, 1, '0, '0, 4'd3, 16'h1234);
        bus.Req[0] = 1'b1;
        tick();
        bus.Req[0] = 1'b0;
        tick(); tick();
        set_txn(0, 0, 4'd3, 4'd0, '0, '0);
        bus.Req[0] = 1'b1;
        tick();
        check("wr_gnt0", bus.Gnt, 2'b01);
        bus.Req[0] = 1'b0;
        tick();
        check("wr_vld0", bus.Vld, 2'b01);
        check("wr_rda0", bus.RDataA[0], 16'h1234);
        check("wr_rdb0", bus.RDataB[0], 16'h0000);
        tick();

        // Simultaneous requests from reset: 0 first, then 1, pointer back at 0
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        rand_txn(0); rand_txn(1);
        bus.We = 2'b00;
        bus.Req = 2'b11;
        tick();
        check("sim_first", bus.Gnt, 2'b01);
        bus.Req[0] = 1'b0;
        tick(); tick();
        check("sim_second", bus.Gnt, 2'b10);
        bus.Req[1] = 1'b0;
        tick(); tick();
        bus.Req = 2'b11;
        tick();
        check("sim_ptr_back", bus.Gnt, 2'b01);
        bus.Req[0] = 1'b0;
        tick(); tick();
        bus.Req[1] = 1'b0;
        tick(); tick();

        // Continuous contention: strict alternation, one grant per two cycles
        rand_txn(0); rand_txn(1);
        bus.Req = 2'b11;
        last = -1; grants = 0;
        for (int c = 0; c < 20 && grants < 6; c++) begin
            tick();
            check("cont_busy", bus.Busy, 1);
            if (bus.Gnt != 2'b00) begin
                w = bus.Gnt[1] ? 1 : 0;
                if (last >= 0) check("cont_alt", w, 1 - last);
                last = w;
                grants++;
                rand_txn(w);
            end
        end
        check("cont_count", grants, 6);
        bus.Req = 2'b00;
        tick(); tick(); tick();

        // Requester 1 writes R15, requester 0 reads it back
        set_txn(1, 1, '0, '0, 4'd15, 16'hFFFF);
        bus.Req[1] = 1'b1;
        tick();
        bus.Req[1] = 1'b0;
        tick(); tick();
        set_txn(0, 0, 4'd15, 4'd3, '0, '0);
        bus.Req[0] = 1'b1;
        tick();
        bus.Req[0] = 1'b0;
        tick();
        check("xreq_rda0", bus.RDataA[0], 16'hFFFF);
        tick();

        // Idle: enables low, captured data held while read buses float
        tick(); tick();
        check("idle_ren0", bus.RF_R_en0, 0);
        check("idle_ren1", bus.RF_R_en1, 0);
        check("idle_wen", bus.RF_W_en, 0);
        check("idle_hold", bus.RDataA[0], 16'hFFFF);

        // Random traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            for (int x = 0; x < 2; x++)
                if (!bus.Req[x] && $urandom_range(0, 2) == 0) begin
                    rand_txn(x);
                    bus.Req[x] = 1'b1;
                end
            rst_n = ($urandom_range(0, 60) != 0);
            tick();
            for (int x = 0; x < 2; x++)
                if (bus.Gnt[x]) begin
                    if ($urandom_range(0, 1) == 1) rand_txn(x);
                    else bus.Req[x] = 1'b0;
                end
        end
        rst_n = 1'b1;
        bus.Req = 2'b00;
        tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
